// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data SRAM behind the MEM-stage load/store request interface.
// It adds programmable wait states, byte-lane steering and load sign/zero extension.
// Optional feature macro: DMEM_MISALIGN_ERR_EN. When it is defined, misaligned accesses are
// suppressed and flagged on the misalign port. When it is undefined, they are silently aligned.
module dmem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall_mem,
   output logic [31:0] rdata
`ifdef DMEM_MISALIGN_ERR_EN
   ,
   output logic        misalign
`endif
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = 4;

   logic [31:0]   r_mem [MEM_WORDS];

   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_type_ok;
   logic [1:0]    w_lo;
   logic [3:0]    w_mask;
   logic [31:0]   w_wrep;
   logic [31:0]   w_word;
   logic [31:0]   w_sh;
   logic [31:0]   w_ext;
   logic [31:0]   w_load_val;
   logic          w_block;
   logic          w_store_ok;
   logic          w_commit;

   assign w_in_range = (req_addr >> (AW + 2)) == 32'd0;
   assign w_idx      = req_addr[AW+1:2];
   assign w_word     = w_in_range ? r_mem[w_idx] : 32'd0;

   // Size decode: effective (aligned) lane, store byte mask and lane-replicated store data
   always_comb begin
      w_type_ok = 1'b0;
      w_lo      = 2'b00;
      w_mask    = 4'b0000;
      w_wrep    = 32'd0;
      case (req_type)
         3'b000, 3'b100: begin
            w_type_ok = 1'b1;
            w_lo      = req_addr[1:0];
            w_mask    = 4'b0001 << req_addr[1:0];
            w_wrep    = {4{req_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            w_type_ok = 1'b1;
            w_lo      = {req_addr[1], 1'b0};
            w_mask    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wrep    = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            w_type_ok = 1'b1;
            w_mask    = 4'b1111;
            w_wrep    = req_wdata;
         end
         default: ;
      endcase
   end

   assign w_sh = w_word >> {w_lo, 3'b000};

   // Load extension; unused encodings read as zero
   always_comb begin
      w_ext = 32'd0;
      case (req_type)
         3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
         3'b100:  w_ext = {24'd0, w_sh[7:0]};
         3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
         3'b101:  w_ext = {16'd0, w_sh[15:0]};
         3'b010:  w_ext = w_word;
         default: w_ext = 32'd0;
      endcase
   end

`ifdef DMEM_MISALIGN_ERR_EN
   logic w_misal;
   assign w_misal = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_type == 3'b010) && (req_addr[1:0] != 2'b00));
   assign w_block = w_misal;
`else
   assign w_block = 1'b0;
`endif

   // A combined read+write is a store, so it never returns load data
   assign w_store_ok = req_write & w_in_range & w_type_ok & ~w_block;
   assign w_load_val = (req_read & ~req_write & w_in_range & ~w_block) ? w_ext : 32'd0;

   // Storage write port: lane-masked, contents survive reset
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
         end
      end
   end

   generate
      if (LATENCY == 0) begin : g_single
         assign stall_mem = 1'b0;
         assign rdata     = w_load_val;
         assign w_commit  = w_store_ok & rst_n;
`ifdef DMEM_MISALIGN_ERR_EN
         assign misalign  = (req_read | req_write) & w_misal;
`endif
      end else begin : g_fsm
         typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

         state_t        r_state;
         state_t        w_next;
         logic [CW-1:0] r_cnt;
         logic [31:0]   r_rdata;
         logic          w_done_edge;

         // State register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_state <= S_IDLE;
            else        r_state <= w_next;
         end

         // Next state and stall; the request cycle itself stalls, DONE never does
         always_comb begin
            w_next      = r_state;
            stall_mem   = 1'b0;
            w_done_edge = 1'b0;
            case (r_state)
               S_IDLE: begin
                  if (req_read | req_write) begin
                     stall_mem = rst_n;
                     w_next    = S_BUSY;
                  end
               end
               S_BUSY: begin
                  stall_mem = 1'b1;
                  if (r_cnt == '0) begin
                     w_next      = S_DONE;
                     w_done_edge = 1'b1;
                  end
               end
               S_DONE:  w_next = S_IDLE;
               default: w_next = S_IDLE;
            endcase
         end

         // Wait-state counter: BUSY lasts LATENCY cycles
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (r_state == S_IDLE && (req_read | req_write)) begin
               r_cnt <= CW'(LATENCY - 1);
            end else if (r_state == S_BUSY && r_cnt != '0) begin
               r_cnt <= r_cnt - CW'(1);
            end
         end

         // Load data captured on the BUSY->DONE edge, held until the next load completes
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                       r_rdata <= 32'd0;
            else if (w_done_edge && req_read) r_rdata <= w_load_val;
         end

         assign rdata    = r_rdata;
         assign w_commit = w_done_edge & w_store_ok;

`ifdef DMEM_MISALIGN_ERR_EN
         logic r_misalign;
         // Misalign flag: single-cycle pulse in DONE
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_misalign <= 1'b0;
            else        r_misalign <= w_done_edge & w_misal;
         end
         assign misalign = r_misalign;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus hand-written reset/hold/misalign sequences.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        req_read;
   logic        req_write;
   logic [2:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall_mem;
   logic [31:0] rdata;
`ifdef DMEM_MISALIGN_ERR_EN
   logic        misalign;
`endif

   int checks = 0;
   int errors = 0;

   dmem_responder #(.MEM_WORDS(1024), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_read  (req_read),
      .req_write (req_write),
      .req_type  (req_type),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .stall_mem (stall_mem),
      .rdata     (rdata)
`ifdef DMEM_MISALIGN_ERR_EN
      ,
      .misalign  (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Runs one access from IDLE, returns sampled in DONE; request dropped afterwards
   task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic chk, input logic [31:0] exp, input logic exp_mis);
      int n;
      @(negedge clk);
      req_read = rd; req_write = wr; req_type = typ; req_addr = addr; req_wdata = wdata;
      #1;
      n = 0;
      while (stall_mem && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      check({nm, " stall_cycles"}, 32'(n), 32'(LAT + 1));
      if (chk) check({nm, " rdata"}, rdata, exp);
`ifdef DMEM_MISALIGN_ERR_EN
      check({nm, " misalign"}, 32'(misalign), 32'(exp_mis));
`else
      if (exp_mis) check({nm, " misalign_unexpected"}, 32'(1'b0), 32'(exp_mis));
`endif
      req_read = 1'b0; req_write = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_w;
      int n;
      rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0;
      req_type = 3'b010; req_addr = 32'd0; req_wdata = 32'd0;

      //                 rd    wr    typ     addr           wdata         chk   exp
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'hAAAAAA80, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,        1'b1, 32'hFFFFFF80});
      vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0,        1'b1, 32'h00000080});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        1'b1, 32'h80000000});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0,        1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h55558001, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0,        1'b1, 32'hFFFF8001});
      vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'h0,        1'b1, 32'h00008001});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,        1'b1, 32'h80010000});
      vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0022, 32'h0,        1'b1, 32'h00000001});
      vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0023, 32'h0,        1'b1, 32'hFFFFFF80});
      vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0001_0010, 32'h11111111, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        1'b1, 32'h80000000});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0001_0010, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0050, 32'h5A5A5A5A, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0,        1'b1, 32'h5A5A5A5A});
      vecs.push_back('{1'b0, 1'b1, 3'b111, 32'h0000_0050, 32'h0,        1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0,        1'b1, 32'h5A5A5A5A});

      // Reset state
      repeat (2) @(negedge clk);
      check("reset stall_mem", 32'(stall_mem), 32'd0);
      check("reset rdata", rdata, 32'd0);
`ifdef DMEM_MISALIGN_ERR_EN
      check("reset misalign", 32'(misalign), 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].typ, vecs[i].addr,
                vecs[i].wdata, vecs[i].chk, vecs[i].exp, 1'b0);
      end

      // Request held through DONE: no retrigger, DONE does not stall
      @(negedge clk);
      req_read = 1'b0; req_write = 1'b1; req_type = 3'b010;
      req_addr = 32'h0000_0060; req_wdata = 32'hA5A5_0001;
      #1;
      n = 0;
      while (stall_mem && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("hold stall_cycles", 32'(n), 32'(LAT + 1));
      check("hold stall_in_done", 32'(stall_mem), 32'd0);
      @(negedge clk);
      #1;
      check("hold idle_restall", 32'(stall_mem), 32'd1);
      req_write = 1'b0;
      @(negedge clk);
      #1;
      check("hold back_to_idle", 32'(stall_mem), 32'd0);
      access("hold readback", 1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h0, 1'b1, 32'hA5A50001, 1'b0);

      // Reset during BUSY aborts the pending store
      access("rst pre_store", 1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      req_write = 1'b1; req_type = 3'b010; req_addr = 32'h0000_0030; req_wdata = 32'h12345678;
      @(negedge clk);
      #1;
      check("rst busy_stall", 32'(stall_mem), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst stall_drop", 32'(stall_mem), 32'd0);
      check("rst rdata_clear", rdata, 32'd0);
      repeat (3) @(negedge clk);
      req_write = 1'b0;
      rst_n = 1'b1;
      access("rst readback", 1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

      // Misaligned accesses
      access("mis init", 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1234ABCD, 1'b0, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
      access("mis lh41", 1'b1, 1'b0, 3'b001, 32'h0000_0041, 32'h0, 1'b1, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      check("mis pulse_end", 32'(misalign), 32'd0);
      access("mis lhu43", 1'b1, 1'b0, 3'b101, 32'h0000_0043, 32'h0, 1'b1, 32'h0, 1'b1);
      access("mis sw42", 1'b0, 1'b1, 3'b010, 32'h0000_0042, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
      exp_w = 32'h1234ABCD;
`else
      access("mis lh41", 1'b1, 1'b0, 3'b001, 32'h0000_0041, 32'h0, 1'b1, 32'hFFFFABCD, 1'b0);
      access("mis lhu43", 1'b1, 1'b0, 3'b101, 32'h0000_0043, 32'h0, 1'b1, 32'h00001234, 1'b0);
      access("mis sw42", 1'b0, 1'b1, 3'b010, 32'h0000_0042, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exp_w = 32'hFFFFFFFF;
`endif
      access("mis lw40", 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1, exp_w, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
